// File: rtl/alu_cmd_sequencer_if.sv
`default_nettype none
// alu_cmd_sequencer_if: command and response valid/ready bundle for alu_cmd_sequencer.
// Rev 1.0
interface alu_cmd_sequencer_if #(
   parameter int TAG_W = 2
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_sel;
   logic [3:0]       cmd_a;
   logic [3:0]       cmd_b;
   logic [TAG_W-1:0] cmd_tag;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [3:0]       rsp_result;
   logic [2:0]       rsp_sel;
   logic [TAG_W-1:0] rsp_tag;

   modport master (
      output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_tag, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_result, rsp_sel, rsp_tag
   );

   modport slave (
      input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_tag, rsp_ready,
      output cmd_ready, rsp_valid, rsp_result, rsp_sel, rsp_tag
   );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// alu_cmd_sequencer: buffers tagged commands, issues them to a registered 4-bit ALU under a
// response-credit limit and collects results in command order. Rev 1.0
module alu_cmd_sequencer #(
   parameter int CMD_DEPTH = 4,
   parameter int RSP_DEPTH = 4,
   parameter int TAG_W     = 2
) (
   input  wire logic                     clk,
   input  wire logic                     reset,
   alu_cmd_sequencer_if.slave            bus,
   output logic [3:0]                    alu_a,
   output logic [3:0]                    alu_b,
   output logic [2:0]                    alu_sel,
   input  wire logic [3:0]               alu_result,
   output logic [$clog2(CMD_DEPTH):0]    cmd_count
);
   localparam int CAW = $clog2(CMD_DEPTH);
   localparam int RAW = $clog2(RSP_DEPTH);
   localparam logic [CAW:0]   CMD_ONE    = {{CAW{1'b0}}, 1'b1};
   localparam logic [RAW:0]   RSP_ONE    = {{RAW{1'b0}}, 1'b1};
   localparam logic [RAW+1:0] CREDIT_MAX = (RAW+2)'(RSP_DEPTH);

   typedef struct packed {
      logic [2:0]       sel;
      logic [3:0]       a;
      logic [3:0]       b;
      logic [TAG_W-1:0] tag;
   } cmd_t;

   typedef struct packed {
      logic [3:0]       result;
      logic [2:0]       sel;
      logic [TAG_W-1:0] tag;
   } rsp_t;

   cmd_t             cmd_mem [CMD_DEPTH];
   rsp_t             rsp_mem [RSP_DEPTH];
   logic [CAW:0]     cmd_wp;
   logic [CAW:0]     cmd_rp;
   logic [RAW:0]     rsp_wp;
   logic [RAW:0]     rsp_rp;
   logic             s1_v;
   logic             s2_v;
   logic [TAG_W-1:0] s1_tag;
   logic [TAG_W-1:0] s2_tag;
   logic [2:0]       s1_sel;
   logic [2:0]       s2_sel;

   logic             cmd_full;
   logic             cmd_empty;
   logic             rsp_full;
   logic             rsp_empty;
   logic             push;
   logic             issue;
   logic             capture;
   logic             rsp_pop;
   logic [RAW:0]     rsp_count;
   logic [RAW+1:0]   in_flight;
   cmd_t             cmd_head;
   rsp_t             rsp_head;

   // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
   assign cmd_full  = (cmd_wp[CAW] != cmd_rp[CAW]) && (cmd_wp[CAW-1:0] == cmd_rp[CAW-1:0]);
   assign cmd_empty = (cmd_wp == cmd_rp);
   assign cmd_count = cmd_wp - cmd_rp;
   assign cmd_head  = cmd_mem[cmd_rp[CAW-1:0]];

   assign rsp_full  = (rsp_wp[RAW] != rsp_rp[RAW]) && (rsp_wp[RAW-1:0] == rsp_rp[RAW-1:0]);
   assign rsp_empty = (rsp_wp == rsp_rp);
   assign rsp_count = rsp_wp - rsp_rp;
   assign rsp_head  = rsp_mem[rsp_rp[RAW-1:0]];

   assign bus.cmd_ready = reset && !cmd_full;
   assign push          = bus.cmd_valid && bus.cmd_ready;

   // Every issued op owns a response slot until it is popped, so the ALU never overruns us.
   assign in_flight = {{(RAW+1){1'b0}}, s1_v} + {{(RAW+1){1'b0}}, s2_v} + {1'b0, rsp_count};
   assign issue     = !cmd_empty && (in_flight < CREDIT_MAX);
   assign capture   = s2_v;

   assign bus.rsp_valid  = !rsp_empty;
   assign rsp_pop        = bus.rsp_valid && bus.rsp_ready;
   assign bus.rsp_result = rsp_empty ? 4'd0 : rsp_head.result;
   assign bus.rsp_sel    = rsp_empty ? 3'd0 : rsp_head.sel;
   assign bus.rsp_tag    = rsp_empty ? '0   : rsp_head.tag;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_wp  <= '0;
         cmd_rp  <= '0;
         rsp_wp  <= '0;
         rsp_rp  <= '0;
         s1_v    <= 1'b0;
         s2_v    <= 1'b0;
         s1_tag  <= '0;
         s2_tag  <= '0;
         s1_sel  <= 3'd0;
         s2_sel  <= 3'd0;
         alu_a   <= 4'd0;
         alu_b   <= 4'd0;
         alu_sel <= 3'd0;
      end else begin
         if (push) begin
            cmd_wp <= cmd_wp + CMD_ONE;
         end
         s1_v <= issue;
         if (issue) begin
            cmd_rp  <= cmd_rp + CMD_ONE;
            alu_a   <= cmd_head.a;
            alu_b   <= cmd_head.b;
            alu_sel <= cmd_head.sel;
            s1_tag  <= cmd_head.tag;
            s1_sel  <= cmd_head.sel;
         end
         // Stage 2 lines up with the edge on which the ALU registers its Result.
         s2_v   <= s1_v;
         s2_tag <= s1_tag;
         s2_sel <= s1_sel;
         if (capture) begin
            rsp_wp <= rsp_wp + RSP_ONE;
         end
         if (rsp_pop) begin
            rsp_rp <= rsp_rp + RSP_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         cmd_mem[cmd_wp[CAW-1:0]] <= '{sel: bus.cmd_sel, a: bus.cmd_a, b: bus.cmd_b, tag: bus.cmd_tag};
      end
      if (capture) begin
         rsp_mem[rsp_wp[RAW-1:0]] <= '{result: alu_result, sel: s2_sel, tag: s2_tag};
      end
   end

   a_no_rsp_overflow : assert property (@(posedge clk) disable iff (!reset)
      !(capture && rsp_full && !rsp_pop));

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// tb_alu_cmd_sequencer: directed vectors plus random traffic checked against a queue-based model.
// Rev 1.0
module tb_alu_cmd_sequencer;
   localparam int TAG_W = 2;

   logic       clk;
   logic       reset;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_sel;
   logic [3:0] alu_result;
   logic [2:0] cmd_count;

   alu_cmd_sequencer_if #(.TAG_W(TAG_W)) bus ();

   alu_cmd_sequencer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .alu_result (alu_result),
      .cmd_count  (cmd_count)
   );

   typedef struct {
      logic [2:0]       sel;
      logic [3:0]       a;
      logic [3:0]       b;
      logic [TAG_W-1:0] tag;
      logic [3:0]       exp;
   } vec_t;

   vec_t        tbl [11];
   logic [15:0] exp_q [$];
   logic [15:0] got_q [$];
   int          got_cyc [$];
   int          tests = 0;
   int          fails = 0;
   int          n_acc = 0;
   int          n_rsp = 0;
   int          cyc = 0;

   function automatic logic [3:0] alu_ref(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
      int x, y, r;
      x = int'(a);
      y = int'(b);
      case (s)
         3'd0:    r = (x + y) % 16;
         3'd1:    r = (x - y + 16) % 16;
         3'd2:    r = x & y;
         3'd3:    r = x | y;
         3'd4:    r = (x * y) % 16;
         3'd5:    r = x ^ y;
         3'd6:    r = 15 - (x & y);
         default: r = 15 - (x | y);
      endcase
      return r[3:0];
   endfunction

   function automatic logic [15:0] mkword(input logic [3:0] res, input logic [2:0] s, input logic [TAG_W-1:0] t);
      return 16'({res, s, t});
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Registered ALU stand-in.
   always @(posedge clk or negedge reset) begin
      if (!reset) alu_result <= 4'd0;
      else        alu_result <= alu_ref(alu_sel, alu_a, alu_b);
   end

   // Monitor: handshakes seen at the falling edge complete on the following rising edge.
   initial begin
      logic        stall_prev;
      logic [15:0] prev_word;
      logic [15:0] word;
      stall_prev = 1'b0;
      prev_word  = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            stall_prev = 1'b0;
         end else begin
            word = mkword(bus.rsp_result, bus.rsp_sel, bus.rsp_tag);
            if (stall_prev && bus.rsp_valid) check("rsp_hold", word, prev_word);
            if (bus.cmd_valid && bus.cmd_ready) begin
               exp_q.push_back(mkword(alu_ref(bus.cmd_sel, bus.cmd_a, bus.cmd_b), bus.cmd_sel, bus.cmd_tag));
               n_acc++;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL rsp_unexpected: got %0h, required no response", word);
               end else begin
                  check("rsp_order", word, exp_q.pop_front());
               end
               got_q.push_back(word);
               got_cyc.push_back(cyc);
               n_rsp++;
            end
            stall_prev = bus.rsp_valid && !bus.rsp_ready;
            prev_word  = word;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the command is taken, valid left high.
   task automatic send(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b, input logic [TAG_W-1:0] t);
      int n;
      n = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_sel   = s;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_tag   = t;
      @(negedge clk);
      while (!bus.cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("cmd_accept", bus.cmd_ready, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      @(negedge clk);
      while ((bus.rsp_valid || exp_q.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat, base, a0, r0;
      logic acc;

      tbl[0]  = '{3'd0, 4'd3, 4'd4, 2'd1, 4'h7};
      tbl[1]  = '{3'd1, 4'd2, 4'd5, 2'd2, 4'hD};
      tbl[2]  = '{3'd4, 4'd6, 4'd3, 2'd3, 4'h2};
      tbl[3]  = '{3'd0, 4'hA, 4'h6, 2'd0, 4'h0};
      tbl[4]  = '{3'd1, 4'hA, 4'h6, 2'd1, 4'h4};
      tbl[5]  = '{3'd2, 4'hA, 4'h6, 2'd2, 4'h2};
      tbl[6]  = '{3'd3, 4'hA, 4'h6, 2'd3, 4'hE};
      tbl[7]  = '{3'd4, 4'hA, 4'h6, 2'd0, 4'hC};
      tbl[8]  = '{3'd5, 4'hA, 4'h6, 2'd1, 4'hC};
      tbl[9]  = '{3'd6, 4'hA, 4'h6, 2'd2, 4'hD};
      tbl[10] = '{3'd7, 4'hA, 4'h6, 2'd3, 4'h1};

      reset         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_sel   = 3'd0;
      bus.cmd_a     = 4'd0;
      bus.cmd_b     = 4'd0;
      bus.cmd_tag   = '0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cmd_ready", bus.cmd_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_alu", {alu_a, alu_b, alu_sel}, 0);
      check("rst_rsp_word", mkword(bus.rsp_result, bus.rsp_sel, bus.rsp_tag), 0);
      check("rst_cmd_count", cmd_count, 0);
      reset = 1'b1;
      #1;
      check("rel_cmd_ready", bus.cmd_ready, 1);
      @(posedge clk);
      #1;

      // Single ops: first rsp_valid exactly three edges after acceptance.
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].tag);
         bus.cmd_valid = 1'b0;
         lat = -1;
         for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
               lat = j;
               break;
            end
            @(posedge clk);
         end
         check("single_latency", lat, 3);
         check("single_word", mkword(bus.rsp_result, bus.rsp_sel, bus.rsp_tag),
               mkword(tbl[i].exp, tbl[i].sel, tbl[i].tag));
         @(posedge clk);
         #1;
         wait_drain();
      end

      // All eight opcodes back to back.
      base = got_q.size();
      for (int i = 3; i < 11; i++) send(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].tag);
      bus.cmd_valid = 1'b0;
      wait_drain();
      check("stream_count", got_q.size() - base, 8);
      for (int k = 0; k < 8; k++) begin
         if (base + k < got_q.size()) begin
            check("stream_word", got_q[base+k], mkword(tbl[3+k].exp, tbl[3+k].sel, tbl[3+k].tag));
            check("stream_no_bubble", got_cyc[base+k] - got_cyc[base], k);
         end
      end

      // Backpressure: four results parked, four commands queued, then drain.
      bus.rsp_ready = 1'b0;
      a0 = n_acc;
      bus.cmd_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         bus.cmd_sel = 3'($urandom);
         bus.cmd_a   = 4'($urandom);
         bus.cmd_b   = 4'($urandom);
         bus.cmd_tag = TAG_W'($urandom);
         @(posedge clk);
         #1;
      end
      check("bp_accepted", n_acc - a0, 8);
      check("bp_cmd_ready", bus.cmd_ready, 0);
      check("bp_cmd_count", cmd_count, 4);
      check("bp_rsp_valid", bus.rsp_valid, 1);
      bus.cmd_valid = 1'b0;
      r0 = n_rsp;
      bus.rsp_ready = 1'b1;
      wait_drain();
      check("bp_drained", n_rsp - r0, 8);

      // Random traffic with random consumer stalls; pointers wrap many times.
      a0  = n_acc;
      acc = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!bus.cmd_valid || acc) begin
            bus.cmd_valid = ($urandom % 3) != 0;
            bus.cmd_sel   = 3'($urandom);
            bus.cmd_a     = 4'($urandom);
            bus.cmd_b     = 4'($urandom);
            bus.cmd_tag   = TAG_W'($urandom);
         end
         bus.rsp_ready = ($urandom % 4) != 0;
         @(negedge clk);
         acc = bus.cmd_valid && bus.cmd_ready;
         @(posedge clk);
         #1;
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      wait_drain();
      check("rand_wrap_ops", (n_acc - a0) >= 20, 1);

      // Reset with operations in flight and queued.
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(3'(i), 4'(i + 1), 4'(i + 7), TAG_W'(i));
      bus.cmd_valid = 1'b0;
      reset = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_cmd_ready", bus.cmd_ready, 0);
      check("mid_rst_rsp_valid", bus.rsp_valid, 0);
      check("mid_rst_alu", {alu_a, alu_b, alu_sel}, 0);
      check("mid_rst_rsp_word", mkword(bus.rsp_result, bus.rsp_sel, bus.rsp_tag), 0);
      check("mid_rst_cmd_count", cmd_count, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("mid_rel_cmd_ready", bus.cmd_ready, 1);
      @(posedge clk);
      #1;
      r0 = n_rsp;
      bus.rsp_ready = 1'b1;
      send(3'd3, 4'h5, 4'hA, 2'd1);
      bus.cmd_valid = 1'b0;
      wait_drain();
      repeat (10) @(posedge clk);
      #1;
      check("post_rst_rsp_count", n_rsp - r0, 1);
      if (got_q.size() > 0) check("post_rst_word", got_q[got_q.size()-1], mkword(4'hF, 3'd3, 2'd1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
